// File: rtl/shift_normalizer.sv
// Iterative left-shift normalizer: shifts one bit per clock until normalized and reports the count.
// Optional signed normalization (i_signed port) is enabled by defining SHIFT_NORM_SIGNED_EN.
module shift_normalizer #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [WIDTH-1:0]       i_data,
`ifdef SHIFT_NORM_SIGNED_EN
  input  logic                   i_signed,
`endif
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WIDTH-1:0]       o_data,
  output logic [SHIFT_WIDTH-1:0] o_shift,
  output logic                   o_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_work;
  logic [SHIFT_WIDTH-1:0] r_cnt;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic [WIDTH-1:0]       r_data;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic                   r_zero;
  logic                   w_zero;
  logic                   w_norm;

`ifdef SHIFT_NORM_SIGNED_EN
  logic r_mode;
  // Signed operands are normalized once the sign bit differs from the bit below it.
  assign w_norm = r_mode ? (r_work[WIDTH-1] ^ r_work[WIDTH-2]) : r_work[WIDTH-1];
`else
  assign w_norm = r_work[WIDTH-1];
`endif
  assign w_zero = (r_work == {WIDTH{1'b0}});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_BUSY;
        else         w_next = S_IDLE;
      end
      S_BUSY: begin
        if (w_zero || w_norm) w_next = S_DONE;
        else                  w_next = S_BUSY;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next == S_BUSY);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_work  <= {WIDTH{1'b0}};
      r_cnt   <= {SHIFT_WIDTH{1'b0}};
`ifdef SHIFT_NORM_SIGNED_EN
      r_mode  <= 1'b0;
`endif
      r_data  <= {WIDTH{1'b0}};
      r_shift <= {SHIFT_WIDTH{1'b0}};
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_work <= i_data;
            r_cnt  <= {SHIFT_WIDTH{1'b0}};
`ifdef SHIFT_NORM_SIGNED_EN
            r_mode <= i_signed;
`endif
          end
        end
        S_BUSY: begin
          if (w_zero) begin
            r_zero  <= 1'b1;
            r_data  <= {WIDTH{1'b0}};
            r_shift <= {SHIFT_WIDTH{1'b0}};
          end else if (w_norm) begin
            r_zero  <= 1'b0;
            r_data  <= r_work;
            r_shift <= r_cnt;
          end else begin
            // A nonzero operand normalizes within WIDTH-1 shifts, so r_cnt cannot wrap.
            r_work <= {r_work[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + SHIFT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_data  = r_data;
  assign o_shift = r_shift;
  assign o_zero  = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: stimulus pushes expected results, a monitor pops on o_done.
// Signed-mode vectors run only when SHIFT_NORM_SIGNED_EN is defined.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data = 32'd0;
  logic        sgn = 1'b0;
  logic        o_ready, o_busy, o_done, o_zero;
  logic [31:0] o_data;
  logic [4:0]  o_shift;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        z;
    longint      t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  shift_normalizer #(.WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_data  (data),
`ifdef SHIFT_NORM_SIGNED_EN
    .i_signed(sgn),
`endif
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_data  (o_data),
    .o_shift (o_shift),
    .o_zero  (o_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Monitor: every o_done must match the oldest expectation, including its arrival time.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("o_data", {32'd0, o_data}, {32'd0, e.d});
        check("o_shift", {59'd0, o_shift}, {59'd0, e.s});
        check("o_zero", {63'd0, o_zero}, {63'd0, e.z});
        check("done_time", 64'($time), 64'(e.t));
        check("ready_in_done", {63'd0, o_ready}, 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] d, input logic s, input logic [31:0] ed,
                       input int k, input logic ez, input bit push);
    int n = 0;
    exp_t e;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) check("ready_timeout", 64'd0, 64'd1);
    data  = d;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    e.d = ed;
    e.s = 5'(k);
    e.z = ez;
    e.t = longint'($time) + longint'((k + 1) * 10 + 5);
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {63'd0, (sb.size() == 0 && o_ready)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int n;
    exp_t e;

    // Reset for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_data", {32'd0, o_data}, 64'd0);
    check("rst_shift", {59'd0, o_shift}, 64'd0);
    check("rst_zero", {63'd0, o_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Already normalized
    issue(32'h8000_0000, 1'b0, 32'h8000_0000, 0, 1'b0, 1'b1);
    wait_drain();

    // Worst case: 31 shifts, busy for 32 cycles
    issue(32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0, 1'b1);
    busy_n = 0;
    while (o_busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(busy_n), 64'd32);
    wait_drain();
    check("held_data", {32'd0, o_data}, 64'h8000_0000);
    check("held_shift", {59'd0, o_shift}, 64'd31);

    // Start held high while busy: one result, next accept only in IDLE
    issue(32'h0000_00F0, 1'b0, 32'hF000_0000, 24, 1'b0, 1'b1);
    start = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_start_ready", {63'd0, o_ready}, 64'd1);
    data = 32'h4000_0000;
    @(posedge clk);
    e.d = 32'h8000_0000;
    e.s = 5'd1;
    e.z = 1'b0;
    e.t = longint'($time) + 64'd25;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // More patterns
    issue(32'h0001_2345, 1'b0, 32'h91A2_8000, 15, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);
    wait_drain();

    // Zero operand
    issue(32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b1, 1'b1);
    wait_drain();
    check("held_zero", {63'd0, o_zero}, 64'd1);

    // Reset during third BUSY cycle aborts with no o_done
    issue(32'h0000_0100, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'd0, o_ready}, 64'd1);
    check("abort_busy", {63'd0, o_busy}, 64'd0);
    check("abort_outs", {o_data, 27'd0, o_shift, o_zero, o_done}, 64'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);

`ifdef SHIFT_NORM_SIGNED_EN
    issue(32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 27, 1'b0, 1'b1);
    issue(32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF0, 0, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 31, 1'b0, 1'b1);
    issue(32'h0000_0001, 1'b1, 32'h4000_0000, 30, 1'b0, 1'b1);
    issue(32'h4000_0000, 1'b1, 32'h4000_0000, 0, 1'b0, 1'b1);
    wait_drain();
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
